// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM status encoding and arbiter grant states.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle of the memory arbiter.
interface mem_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;
    logic              arb_err;

    // master: the arbiter itself; slave: the caches and RAM around it
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );
endinterface

// File: rtl/arb_timeout_ctr.sv
// Saturating watchdog counter: clear holds it at 0, expire flags LIMIT-1 cycles counted.
module arb_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt;

    assign expire = (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache single-word requests onto one RAM port, data first.
// ARB_FAIR_EN: after MAX_DSTREAK data completions with icache waiting, force an icache grant.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_DSTREAK = 4
) (
    input logic         CLK,
    input logic         RST,
    mem_arbiter_if.master bus
);
    arb_state_t        state, state_nx;
    logic              d_req, expire, fair_pick, d_done, i_done;
    logic              iwait, dwait, ram_ren, ram_wen, err;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] store_mux;

    assign d_req = bus.dREN | bus.dWEN;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    arb_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_tmo (
        .clk    (CLK),
        .rst    (RST),
        .clr    (state == IDLE),
        .en     ((state != IDLE) && (bus.ramstate != ACCESS)),
        .expire (expire)
    );

`ifdef ARB_FAIR_EN
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    logic [SW-1:0] streak;

    always_ff @(posedge CLK) begin
        if (RST)
            streak <= '0;
        else if (i_done)
            streak <= '0;
        else if (d_done)
            streak <= !bus.iREN ? '0 :
                      (streak >= SW'(MAX_DSTREAK)) ? streak : streak + 1'b1;
    end

    assign fair_pick = (streak >= SW'(MAX_DSTREAK)) && bus.iREN;
`else
    logic unused_fair;
    // keeps the fairness knobs referenced in the strict-priority build
    assign unused_fair = (MAX_DSTREAK > 0) ^ d_done ^ i_done;
    assign fair_pick   = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        iwait     = 1'b1;
        dwait     = 1'b1;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        addr_mux  = '0;
        store_mux = '0;
        err       = 1'b0;
        d_done    = 1'b0;
        i_done    = 1'b0;
        case (state)
            IDLE: begin
                if (fair_pick)       state_nx = IGRANT;
                else if (d_req)      state_nx = DGRANT;
                else if (bus.iREN)   state_nx = IGRANT;
            end
            DGRANT: begin
                ram_ren   = bus.dREN & ~bus.dWEN;
                ram_wen   = bus.dWEN;
                addr_mux  = bus.daddr;
                store_mux = bus.dstore;
                // a withdrawn request ends the grant silently
                if (!d_req) begin
                    state_nx = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    dwait    = 1'b0;
                    d_done   = 1'b1;
                    state_nx = IDLE;
                end else if (bus.ramstate == ERROR || expire) begin
                    err      = 1'b1;
                    state_nx = IDLE;
                end
            end
            IGRANT: begin
                ram_ren  = 1'b1;
                addr_mux = bus.iaddr;
                if (!bus.iREN) begin
                    state_nx = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    iwait    = 1'b0;
                    i_done   = 1'b1;
                    state_nx = IDLE;
                end else if (bus.ramstate == ERROR || expire) begin
                    err      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.iwait    = iwait;
    assign bus.dwait    = dwait;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = addr_mux;
    assign bus.ramstore = store_mux;
    assign bus.arb_err  = err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; status vector is {ramREN, ramWEN, iwait, dwait, arb_err}.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int ADDR_W = 32, DATA_W = 32, TIMEOUT_CYC = 64, MAX_DSTREAK = 4;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_DSTREAK(MAX_DSTREAK)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    logic [4:0] st;
    assign st = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.arb_err};

    task automatic nxt;
        @(posedge CLK); #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    task automatic idle_in;
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
    endtask

    task automatic test_reset;
        RST = 1; idle_in();
        bus.iREN = 1; bus.dREN = 1; bus.daddr = 32'h40; bus.iaddr = 32'h80;
        nxt();
        for (int k = 0; k < 3; k++) begin
            smp(); checks++;
            if (st !== 5'b00110 || bus.ramaddr !== '0 || bus.ramstore !== '0) begin
                errors++; $display("FAIL reset_idle got st=%b addr=%h store=%h exp st=00110 addr=0 store=0", st, bus.ramaddr, bus.ramstore);
            end
            nxt();
        end
        RST = 0; smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL reset_release got %b exp 00110", st); end
        nxt(); smp(); checks++;
        if (st !== 5'b10110 || bus.ramaddr !== 32'h40) begin
            errors++; $display("FAIL first_grant_d got st=%b addr=%h exp st=10110 addr=40", st, bus.ramaddr);
        end
        nxt(); bus.dREN = 0; bus.iREN = 0; smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL reset_drop got %b exp 00110", st); end
        nxt();
    endtask

    task automatic test_dread;
        idle_in(); bus.dREN = 1; bus.daddr = 32'h100; bus.ramstate = BUSY;
        smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL dread_req got %b exp 00110", st); end
        nxt(); smp(); checks++;
        if (st !== 5'b10110 || bus.ramaddr !== 32'h100) begin
            errors++; $display("FAIL dread_strobe got st=%b addr=%h exp st=10110 addr=100", st, bus.ramaddr);
        end
        nxt(); bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF; smp(); checks++;
        if (st !== 5'b10100) begin errors++; $display("FAIL dread_wait got %b exp 10100", st); end
        checks++;
        if (bus.dload !== 32'hDEADBEEF) begin errors++; $display("FAIL dread_data got %h exp deadbeef", bus.dload); end
        nxt(); bus.dREN = 0; bus.ramstate = FREE; smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL dread_done got %b exp 00110", st); end
        nxt();
    endtask

    task automatic test_write_vs_i;
        idle_in(); bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h5;
        bus.iREN = 1; bus.iaddr = 32'h80; bus.ramstate = BUSY;
        nxt(); smp(); checks++;
        if (st !== 5'b01110 || bus.ramaddr !== 32'h200 || bus.ramstore !== 32'h5) begin
            errors++; $display("FAIL wr_strobe got st=%b addr=%h store=%h exp st=01110 addr=200 store=5", st, bus.ramaddr, bus.ramstore);
        end
        nxt(); smp(); checks++;
        if (st !== 5'b01110) begin errors++; $display("FAIL wr_busy got %b exp 01110", st); end
        nxt(); bus.ramstate = ACCESS; smp(); checks++;
        if (st !== 5'b01100) begin errors++; $display("FAIL wr_done got %b exp 01100", st); end
        nxt(); bus.dWEN = 0; bus.ramstate = FREE; smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL wr_bubble got %b exp 00110", st); end
        nxt(); bus.ramstate = BUSY; smp(); checks++;
        if (st !== 5'b10110 || bus.ramaddr !== 32'h80 || bus.ramstore !== '0) begin
            errors++; $display("FAIL i_grant got st=%b addr=%h store=%h exp st=10110 addr=80 store=0", st, bus.ramaddr, bus.ramstore);
        end
        nxt(); bus.ramstate = ACCESS; bus.ramload = 32'h12345678; smp(); checks++;
        if (st !== 5'b10010 || bus.iload !== 32'h12345678) begin
            errors++; $display("FAIL i_done got st=%b iload=%h exp st=10010 iload=12345678", st, bus.iload);
        end
        nxt(); bus.iREN = 0; bus.ramstate = FREE; smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL i_idle got %b exp 00110", st); end
        nxt();
    endtask

    task automatic test_timeout;
        idle_in(); bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = BUSY;
        nxt();
        for (int g = 1; g < TIMEOUT_CYC; g++) begin
            smp(); checks++;
            if (st !== 5'b10110) begin errors++; $display("FAIL timeout_wait cycle %0d got %b exp 10110", g, st); end
            nxt();
        end
        smp(); checks++;
        if (st !== 5'b10111) begin errors++; $display("FAIL timeout_pulse got %b exp 10111", st); end
        nxt(); smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL timeout_idle got %b exp 00110", st); end
        nxt(); bus.ramstate = ACCESS; smp(); checks++;
        if (st !== 5'b10100 || bus.ramaddr !== 32'h300) begin
            errors++; $display("FAIL timeout_retry got st=%b addr=%h exp st=10100 addr=300", st, bus.ramaddr);
        end
        nxt(); bus.dREN = 0; bus.ramstate = FREE;
        nxt();
    endtask

    task automatic test_error_drop;
        idle_in(); bus.dREN = 1; bus.daddr = 32'h180; bus.ramstate = BUSY;
        nxt(); bus.ramstate = ERROR; smp(); checks++;
        if (st !== 5'b10111) begin errors++; $display("FAIL err_pulse got %b exp 10111", st); end
        nxt(); bus.ramstate = BUSY; smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL err_idle got %b exp 00110", st); end
        nxt(); smp(); checks++;
        if (st !== 5'b10110 || bus.ramaddr !== 32'h180) begin
            errors++; $display("FAIL err_regrant got st=%b addr=%h exp st=10110 addr=180", st, bus.ramaddr);
        end
        nxt(); bus.dREN = 0; smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL drop_no_pulse got %b exp 00110", st); end
        nxt(); smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL drop_idle got %b exp 00110", st); end
        nxt();
    endtask

    task automatic test_fairness;
        logic [9:0] got, exp_order;
        int n;
        got = '0; n = 0;
`ifdef ARB_FAIR_EN
        exp_order = 10'b10_0001_0000;
`else
        exp_order = 10'b00_0000_0000;
`endif
        idle_in(); bus.dREN = 1; bus.iREN = 1;
        bus.daddr = 32'h400; bus.iaddr = 32'h500; bus.ramstate = ACCESS;
        for (int c = 0; c < 40 && n < 10; c++) begin
            smp();
            if (bus.ramREN) begin
                got[n] = (bus.ramaddr == 32'h500);
                n++;
            end
            nxt();
        end
        checks++;
        if (n !== 10) begin errors++; $display("FAIL fair_count got %0d exp 10", n); end
        checks++;
        if (got !== exp_order) begin errors++; $display("FAIL fair_order got %b exp %b (bit0 first, 1=I)", got, exp_order); end
        bus.dREN = 0; bus.iREN = 0; bus.ramstate = FREE;
        nxt(); nxt();
    endtask

    task automatic test_reset_abort;
        idle_in(); bus.dREN = 1; bus.daddr = 32'h600; bus.ramstate = BUSY;
        nxt(); smp(); checks++;
        if (st !== 5'b10110) begin errors++; $display("FAIL abort_grant got %b exp 10110", st); end
        nxt(); RST = 1; smp(); checks++;
        if (st !== 5'b10110) begin errors++; $display("FAIL abort_still got %b exp 10110", st); end
        nxt(); smp(); checks++;
        if (st !== 5'b00110 || bus.ramaddr !== '0) begin
            errors++; $display("FAIL abort_dropped got st=%b addr=%h exp st=00110 addr=0", st, bus.ramaddr);
        end
        RST = 0; bus.dREN = 0;
        nxt(); smp(); checks++;
        if (st !== 5'b00110) begin errors++; $display("FAIL abort_idle got %b exp 00110", st); end
        nxt();
    endtask

    initial begin
        test_reset();
        test_dread();
        test_write_vs_i();
        test_timeout();
        test_error_drop();
        test_fairness();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches and arbitrates their single-word requests onto the one shared RAM port.
- Returns per-cache wait and load data to the caches.
- Data cache has priority, because its multi-word fills and writebacks must complete before the halt flush.
- Registered grant FSM with a RAM-latency timeout.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.
- TIMEOUT_CYC, 64, cycles a granted access may wait for RAM before it is abandoned.
- MAX_DSTREAK, 4, consecutive data grants before a pending instruction request is forced in (only with ARB_FAIR_EN).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache word address.
- iwait  out  1  low for exactly one cycle when iload is valid.
- iload  out  DATA_W  instruction word from RAM.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache word address.
- dstore  in  DATA_W  dcache write data.
- dwait  out  1  low for exactly one cycle when the access completes.
- dload  out  DATA_W  data word from RAM.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- arb_err  out  1  one-cycle pulse on RAM ERROR or timeout.

Behaviour:
- Reset (RST high at an edge):
  - State goes to IDLE; timeout counter and streak counter clear.
  - Outputs while in reset/IDLE: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, arb_err=0.
  - iload/dload are combinational copies of ramload at all times.
  - RST asserted mid-access aborts the access: RAM strobes drop the cycle after the reset edge; no completion is reported.
- States: IDLE, DGRANT, IGRANT.
- IDLE:
  - (dREN|dWEN) -> DGRANT; else iREN -> IGRANT; else stay.
  - Simultaneous d and i requests: data wins.
- DGRANT:
  - ramREN = dREN & ~dWEN; ramWEN = dWEN (write wins if both asserted); ramaddr = daddr; ramstore = dstore.
  - The address is taken live each cycle, not latched.
- IGRANT:
  - ramREN = 1; ramWEN = 0; ramaddr = iaddr; ramstore = 0.
- Completion: in a grant state with ramstate==ACCESS:
  - The owner's wait is 0 combinationally that cycle.
  - Next state is IDLE (one-cycle re-arbitration bubble).
  - Minimum latency from request to wait-low is 2 cycles.
- Non-owner wait stays 1 throughout the grant.
- Owner drops its request while granted (e.g. dREN and dWEN both 0 in DGRANT): return to IDLE next cycle, no wait pulse, no error.
- ramstate==ERROR in a grant state: arb_err=1 that cycle, wait stays 1, go to IDLE. The still-asserted request re-arbitrates (retry).
- Timeout counter:
  - 0 on grant entry; increments each grant cycle without ACCESS.
  - When count == TIMEOUT_CYC-1 and no ACCESS: arb_err pulse, go to IDLE.
  - Counter width clog2(TIMEOUT_CYC); never wraps.
- Back-to-back fills: a cache holding its request across words gets one grant per word. Data can re-win IDLE indefinitely (starvation allowed without the option).

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined:
  - Streak counter increments on each DGRANT completion while iREN is high.
  - It clears on any IGRANT completion, or on a DGRANT completion while iREN is low.
  - When streak == MAX_DSTREAK and iREN is high in IDLE, IGRANT is chosen over data; the streak then clears on that completion.
- Undefined: strict data priority; streak counter absent.

Decomposition:
- Shared package (cpu_types_pkg): ramstate_t enum (FREE, BUSY, ACCESS, ERROR) and arb_state_t enum (IDLE, DGRANT, IGRANT).
- One natural sub-module: arb_timeout_ctr (load/clear, enable, expire output), reused for RAM-latency watchdogs elsewhere.

Test Plan:
- Reset with iREN=1, dREN=1 held -> all strobes 0, iwait=dwait=1 until the cycle after RST falls; first grant is DGRANT.
- dREN, daddr=0x100, RAM returns ACCESS one cycle after the strobe with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100, dwait low one cycle with dload=0xDEADBEEF, iwait stays 1.
- iREN and dWEN requested the same cycle (daddr=0x200, dstore=0x5), 3-cycle RAM -> data write completes first, then IGRANT after a one-cycle IDLE bubble.
- ramstate stuck BUSY for TIMEOUT_CYC=64 cycles -> arb_err pulses at grant cycle 64, returns to IDLE, request is retried.
- ramstate=ERROR mid-grant -> single arb_err pulse, no wait-low, regrant next cycle; owner drops request mid-grant -> IDLE with no pulse.
- With ARB_FAIR_EN, MAX_DSTREAK=4: continuous dREN plus iREN -> grant order D,D,D,D,I,D,D,D,D,I; without the macro, I is never granted.
